affine_loop_ctrl: RTL and testbench
===================================

AFFINE_LOOP_CTRL -- requirements
Module: affine_loop_ctrl

Interface
REQ-001 SHALL have parameter W, default 16: width of each control variable.
REQ-002 SHALL have parameter EXTENT_0, default 1: trip count of dimension 0 (outermost).
REQ-003 SHALL have parameter EXTENT_1, default 4: trip count of dimension 1 (channel).
REQ-004 SHALL have parameter EXTENT_2, default 32: trip count of dimension 2 (row).
REQ-005 SHALL have parameter EXTENT_3, default 32: trip count of dimension 3 (innermost, column).
REQ-006 SHALL have parameter START_DELAY, default 0: cycles from flush to the first iteration.
REQ-007 SHALL have parameter II, default 1: initiation interval in cycles, at least 1.
REQ-008 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-010 SHALL have port flush, input, 1 bit: (re)start the schedule.
REQ-011 SHALL have port stall, input, 1 bit: freeze all progress.
REQ-012 SHALL have port valid, output, 1 bit: iteration strobe, drives a buffer port's wen/ren.
REQ-013 SHALL have port ctrl_vars, output, [3:0] x W: current loop indices, [3] innermost.
REQ-014 SHALL have port done, output, 1 bit: schedule complete, sticky.

Function
REQ-015 SHALL implement states IDLE, DELAY, RUN and DONE.
REQ-016 SHALL, when flush is sampled high in any state, clear all dimension counters and the delay and II counters, then enter DELAY, or RUN if START_DELAY=0.
REQ-017 SHALL leave DELAY for RUN after START_DELAY non-stalled cycles.
REQ-018 SHALL, with flush sampled at edge k and no stall, register valid high from edge k+1+START_DELAY, carrying ctrl_vars={0,0,0,0}.
REQ-019 SHALL, in RUN, assert valid for one cycle every II non-stalled cycles; valid SHALL be constantly high when II=1.
REQ-020 SHALL register valid, ctrl_vars and done with no combinational path from inputs.
REQ-021 SHALL advance indices after each issued iteration: ctrl_vars[3] increments; on reaching EXTENT_3-1 it wraps to 0 and carries into [2]; [2] carries into [1], and [1] into [0].
REQ-022 SHALL hold constant 0 in any dimension whose extent is 1.
REQ-023 SHALL, after iteration EXTENT_0*EXTENT_1*EXTENT_2*EXTENT_3 (last indices all EXTENT-1), go to DONE on the next edge, with done=1, valid=0 and ctrl_vars holding the last indices.
REQ-024 SHALL keep ctrl_vars at the last issued value whenever valid=0.
REQ-025 SHALL, while stall=1 in DELAY or RUN, freeze all counters and force valid=0; the issue SHALL resume on the cycle after stall falls, with no iteration skipped or repeated.
REQ-026 SHALL let flush take priority over stall, and rst_n take priority over flush.
REQ-027 SHALL, on flush in RUN or DONE, abandon the schedule, clear done on the next edge, and restart per REQ-016.
REQ-028 SHALL use internal counters wide enough for START_DELAY and II without overflow.

Reset
REQ-029 SHALL, on rst_n=0 at a clock edge, set state IDLE, valid=0, ctrl_vars all 0, done=0, and clear every internal counter.
REQ-030 SHALL abort any in-progress schedule on reset and issue nothing until the next flush.
REQ-031 SHALL keep valid=0 in IDLE regardless of stall.

Structure
REQ-032 SHALL place the state enum, the NDIM=4 constant and the default W in a shared package, affine_ctrl_pkg.
REQ-033 SHALL instantiate one sub-module per dimension, affine_loop_dim_cnt, a wrapping counter with inc_in, carry_out, clear and extent parameter.
REQ-034 SHALL keep the II counter, the delay counter and the FSM in the top level.

Verification
REQ-035 SHALL cover defaults: flush at cycle 5 -> valid rises cycle 6, 4096 consecutive valids, last ctrl_vars={0,3,31,31}, done=1 at cycle 4102.
REQ-036 SHALL cover START_DELAY=10, II=3: flush at cycle 0 -> valids at cycles 11, 14, 17...; ctrl_vars[3] steps 0,1,2.
REQ-037 SHALL cover a stall during RUN: stall 4 cycles at index {0,1,5,7} -> valid low 4 cycles, the next valid carries {0,1,5,8}, total count still 4096.
REQ-038 SHALL cover a wrap: an iteration at {0,0,0,31} -> the next is {0,0,1,0}; {0,0,31,31} -> {0,1,0,0}.
REQ-039 SHALL cover flush mid-RUN at index {0,2,10,3} -> the next edge clears valid/done, a fresh schedule starts at {0,0,0,0}, and 4096 iterations are issued.
REQ-040 SHALL cover rst_n=0 mid-RUN with flush=1 held -> all outputs 0, state IDLE, no valid until a flush after reset is released.

Source files
------------

// File: rtl/affine_ctrl_pkg.sv
// Shared types and constants for the affine loop controller.
// Holds the FSM state encoding, dimension count and default control-variable width.
package affine_ctrl_pkg;

  localparam int NDIM      = 4;
  localparam int W_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_RUN,
    S_DONE
  } state_t;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/affine_loop_dim_cnt.sv
// One loop dimension: a wrapping index counter.
// It advances on inc_in and raises carry_out when it wraps from EXTENT-1 back to 0.
module affine_loop_dim_cnt
  import affine_ctrl_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int EXTENT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc_in,
  output logic [W-1:0] count,
  output logic         carry_out
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  // An extent of 1 keeps the counter permanently at 0, since it is always "at max".
  assign w_at_max  = (r_count == W'(EXTENT - 1));
  assign carry_out = inc_in && w_at_max;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_count <= '0;
    end else if (inc_in) begin
      r_count <= w_at_max ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/affine_loop_ctrl.sv
// Four-deep affine loop-nest sequencer.
// It issues one registered iteration strobe with its loop indices every II cycles after an optional start delay.
module affine_loop_ctrl
  import affine_ctrl_pkg::*;
#(
  parameter int W           = W_DEFAULT,
  parameter int EXTENT_0    = 1,
  parameter int EXTENT_1    = 4,
  parameter int EXTENT_2    = 32,
  parameter int EXTENT_3    = 32,
  parameter int START_DELAY = 0,
  parameter int II          = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   stall,
  output logic                   valid,
  output logic [NDIM-1:0][W-1:0] ctrl_vars,
  output logic                   done
);

  localparam int DW = cnt_width(START_DELAY);
  localparam int IW = cnt_width(II);

  state_t                 r_state;
  logic [DW-1:0]          r_dly;
  logic [IW-1:0]          r_ii;
  logic                   w_issue;
  logic                   w_dly_last;
  logic                   w_ii_last;
  logic [NDIM-1:0]        w_inc;
  logic [NDIM-1:0]        w_carry;
  logic [NDIM-1:0][W-1:0] w_cnt;

  assign w_issue    = rst_n && !flush && !stall && (r_state == S_RUN) && (r_ii == '0);
  assign w_dly_last = (int'(r_dly) >= START_DELAY - 1);
  assign w_ii_last  = (int'(r_ii) >= II - 1);

  // Innermost dimension steps on every issue; each outer one steps on its inner neighbour's carry.
  for (genvar g = 0; g < NDIM; g++) begin : g_dim
    localparam int EXT = (g == 0) ? EXTENT_0 :
                         (g == 1) ? EXTENT_1 :
                         (g == 2) ? EXTENT_2 : EXTENT_3;
    if (g == NDIM - 1) begin : g_inner
      assign w_inc[g] = w_issue;
    end else begin : g_outer
      assign w_inc[g] = w_carry[g+1];
    end
    affine_loop_dim_cnt #(
      .W      (W),
      .EXTENT (EXT)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (flush),
      .inc_in    (w_inc[g]),
      .count     (w_cnt[g]),
      .carry_out (w_carry[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dly     <= '0;
      r_ii      <= '0;
      valid     <= 1'b0;
      done      <= 1'b0;
      ctrl_vars <= '0;
    end else if (flush) begin
      r_state <= (START_DELAY == 0) ? S_RUN : S_DELAY;
      r_dly   <= '0;
      r_ii    <= '0;
      valid   <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          valid <= 1'b0;
        end
        S_DELAY: begin
          valid <= 1'b0;
          if (!stall) begin
            if (w_dly_last) r_state <= S_RUN;
            else            r_dly   <= r_dly + 1'b1;
          end
        end
        S_RUN: begin
          if (stall) begin
            valid <= 1'b0;
          end else begin
            valid <= (r_ii == '0);
            r_ii  <= w_ii_last ? '0 : r_ii + 1'b1;
            // State moves to DONE with the last issue, so done rises on the following edge.
            if (r_ii == '0) begin
              ctrl_vars <= w_cnt;
              if (w_carry[0]) r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          valid <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_affine_loop_ctrl.sv
// Directed testbench for affine_loop_ctrl.
// Covers a default-parameter instance and a START_DELAY=10 / II=3 instance.
module tb_affine_loop_ctrl;
  import affine_ctrl_pkg::*;

  localparam int E0 = 1, E1 = 4, E2 = 32, E3 = 32;
  localparam int TOTAL = E0 * E1 * E2 * E3;

  logic clk = 1'b0;
  logic rst_n = 1'b0, flush = 1'b0, stall = 1'b0, flush2 = 1'b0, stall2 = 1'b0;
  logic valid, done, valid2, done2;
  logic [3:0][15:0] cv, cv2;
  int cyc = 0;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  affine_loop_ctrl #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .valid(valid), .ctrl_vars(cv), .done(done)
  );

  affine_loop_ctrl #(.W(16), .START_DELAY(10), .II(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .stall(stall2),
    .valid(valid2), .ctrl_vars(cv2), .done(done2)
  );

  function automatic logic [63:0] pk(input int d0, input int d1, input int d2, input int d3);
    return {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs until done (or maxc cycles), scoring each issued index against a reference nest.
  task automatic collect(input logic [63:0] start, input int maxc,
                         output int nv, output int first_c, output int done_c,
                         output logic [63:0] last_cv, output int seq_err,
                         output logic [63:0] succ1, output logic [63:0] succ2);
    int m[4];
    logic [63:0] prev;
    bit have_prev;
    m[0] = int'(start[15:0]);  m[1] = int'(start[31:16]);
    m[2] = int'(start[47:32]); m[3] = int'(start[63:48]);
    nv = 0; first_c = -1; done_c = -1; seq_err = 0;
    succ1 = '1; succ2 = '1; last_cv = '0; prev = '0; have_prev = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (valid) begin
        nv++;
        if (first_c < 0) first_c = cyc;
        if (cv !== pk(m[0], m[1], m[2], m[3])) seq_err++;
        if (have_prev && prev === pk(0, 0, 0, 31)) succ1 = cv;
        if (have_prev && prev === pk(0, 0, 31, 31)) succ2 = cv;
        prev = cv; have_prev = 1'b1;
        m[3]++;
        if (m[3] == E3) begin
          m[3] = 0; m[2]++;
          if (m[2] == E2) begin
            m[2] = 0; m[1]++;
            if (m[1] == E1) begin m[1] = 0; m[0]++; end
          end
        end
      end
      if (done) begin
        done_c = cyc; last_cv = cv;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int hv;
    while (cyc < 2) tick();
    n_total++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    n_total++; if (cv !== 64'h0) $display("FAIL rst_ctrl: got %h want 0", cv); else n_pass++;
    n_total++; if (dut.r_state !== S_IDLE) $display("FAIL rst_state: got %0d want %0d", dut.r_state, S_IDLE); else n_pass++;
    n_total++; if ({valid2, done2, cv2} !== 66'h0) $display("FAIL rst_dut2: got %h want 0", {valid2, done2, cv2}); else n_pass++;
    rst_n = 1'b1; stall = 1'b1; stall2 = 1'b1;
    hv = 0;
    tick(); if (valid || valid2) hv++;
    tick(); if (valid || valid2) hv++;
    n_total++; if (hv !== 0) $display("FAIL idle_stall_valid: got %0d want 0", hv); else n_pass++;
    stall = 1'b0; stall2 = 1'b0;
  endtask

  task automatic test_defaults;
    int nv, fc, dc, se;
    logic [63:0] lcv, s1, s2;
    flush = 1'b1; tick(); flush = 1'b0;
    n_total++; if (valid !== 1'b0) $display("FAIL def_pre_valid: got %b want 0 at cyc %0d", valid, cyc); else n_pass++;
    collect(pk(0, 0, 0, 0), 4300, nv, fc, dc, lcv, se, s1, s2);
    n_total++; if (fc !== 6) $display("FAIL def_first_cyc: got %0d want 6", fc); else n_pass++;
    n_total++; if (nv !== TOTAL) $display("FAIL def_count: got %0d want %0d", nv, TOTAL); else n_pass++;
    n_total++; if (dc !== 4102) $display("FAIL def_done_cyc: got %0d want 4102", dc); else n_pass++;
    n_total++; if (lcv !== pk(0, 3, 31, 31)) $display("FAIL def_last: got %h want %h", lcv, pk(0, 3, 31, 31)); else n_pass++;
    n_total++; if (se !== 0) $display("FAIL def_sequence: got %0d bad indices want 0", se); else n_pass++;
    n_total++; if (s1 !== pk(0, 0, 1, 0)) $display("FAIL wrap_col: got %h want %h", s1, pk(0, 0, 1, 0)); else n_pass++;
    n_total++; if (s2 !== pk(0, 1, 0, 0)) $display("FAIL wrap_row: got %h want %h", s2, pk(0, 1, 0, 0)); else n_pass++;
    tick(); tick(); tick();
    n_total++; if ({done, valid} !== 2'b10) $display("FAIL done_sticky: got done,valid=%b want 10", {done, valid}); else n_pass++;
    n_total++; if (cv !== pk(0, 3, 31, 31)) $display("FAIL done_hold: got %h want %h", cv, pk(0, 3, 31, 31)); else n_pass++;
  endtask

  task automatic test_ii;
    logic [18:0] obs, expm;
    logic [63:0] got[3];
    int k;
    expm = '0; expm[11] = 1'b1; expm[14] = 1'b1; expm[17] = 1'b1;
    obs = '0; k = 0;
    for (int i = 0; i < 3; i++) got[i] = '1;
    flush2 = 1'b1; tick(); flush2 = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      obs[i] = valid2;
      if (valid2 && k < 3) begin got[k] = cv2; k++; end
    end
    n_total++; if (obs !== expm) $display("FAIL ii_pattern: got %b want %b", obs, expm); else n_pass++;
    n_total++; if (got[0] !== pk(0, 0, 0, 0)) $display("FAIL ii_idx0: got %h want %h", got[0], pk(0, 0, 0, 0)); else n_pass++;
    n_total++; if (got[1] !== pk(0, 0, 0, 1)) $display("FAIL ii_idx1: got %h want %h", got[1], pk(0, 0, 0, 1)); else n_pass++;
    n_total++; if (got[2] !== pk(0, 0, 0, 2)) $display("FAIL ii_idx2: got %h want %h", got[2], pk(0, 0, 0, 2)); else n_pass++;
  endtask

  task automatic test_stall;
    int n, hv, nv, fc, dc, se;
    bit found;
    logic [63:0] lcv, s1, s2;
    flush = 1'b1; tick(); flush = 1'b0;
    n_total++; if ({done, valid} !== 2'b00) $display("FAIL stall_flush_clear: got done,valid=%b want 00", {done, valid}); else n_pass++;
    n = 0; found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      if (valid) begin
        n++;
        if (cv === pk(0, 1, 5, 7)) found = 1'b1;
      end
    end
    n_total++; if (found !== 1'b1) $display("FAIL stall_reach: got %b want 1", found); else n_pass++;
    stall = 1'b1; hv = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (valid) hv++; end
    n_total++; if (hv !== 0) $display("FAIL stall_valid_low: got %0d highs want 0", hv); else n_pass++;
    n_total++; if (cv !== pk(0, 1, 5, 7)) $display("FAIL stall_hold: got %h want %h", cv, pk(0, 1, 5, 7)); else n_pass++;
    stall = 1'b0; tick();
    if (valid) n++;
    n_total++; if ({valid, cv} !== {1'b1, pk(0, 1, 5, 8)}) $display("FAIL stall_resume: got %b/%h want 1/%h", valid, cv, pk(0, 1, 5, 8)); else n_pass++;
    collect(pk(0, 1, 5, 9), 4300, nv, fc, dc, lcv, se, s1, s2);
    n_total++; if (n + nv !== TOTAL) $display("FAIL stall_total: got %0d want %0d", n + nv, TOTAL); else n_pass++;
    n_total++; if (se !== 0) $display("FAIL stall_sequence: got %0d bad indices want 0", se); else n_pass++;
    n_total++; if (dc < 0) $display("FAIL stall_done: got %0d want done reached", dc); else n_pass++;
  endtask

  task automatic test_flush_mid_run;
    int fcyc, nv, fc, dc, se;
    bit found;
    logic [63:0] lcv, s1, s2;
    flush = 1'b1; tick(); flush = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      if (valid && cv === pk(0, 2, 10, 3)) found = 1'b1;
    end
    n_total++; if (found !== 1'b1) $display("FAIL flush_reach: got %b want 1", found); else n_pass++;
    // Stall is held alongside flush; flush must still restart the schedule.
    flush = 1'b1; stall = 1'b1; tick(); fcyc = cyc;
    flush = 1'b0; stall = 1'b0;
    n_total++; if ({done, valid} !== 2'b00) $display("FAIL flush_clear: got done,valid=%b want 00", {done, valid}); else n_pass++;
    collect(pk(0, 0, 0, 0), 4300, nv, fc, dc, lcv, se, s1, s2);
    n_total++; if (fc !== fcyc + 1) $display("FAIL flush_first_cyc: got %0d want %0d", fc, fcyc + 1); else n_pass++;
    n_total++; if (nv !== TOTAL) $display("FAIL flush_count: got %0d want %0d", nv, TOTAL); else n_pass++;
    n_total++; if (se !== 0) $display("FAIL flush_sequence: got %0d bad indices want 0", se); else n_pass++;
    n_total++; if (dc !== fcyc + 1 + TOTAL) $display("FAIL flush_done_cyc: got %0d want %0d", dc, fcyc + 1 + TOTAL); else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int nv;
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_total++; if (valid !== 1'b1) $display("FAIL rmr_running: got %b want 1", valid); else n_pass++;
    rst_n = 1'b0; flush = 1'b1; tick();
    n_total++; if ({valid, done} !== 2'b00) $display("FAIL rmr_outputs: got valid,done=%b want 00", {valid, done}); else n_pass++;
    n_total++; if (cv !== 64'h0) $display("FAIL rmr_ctrl: got %h want 0", cv); else n_pass++;
    n_total++; if (dut.r_state !== S_IDLE) $display("FAIL rmr_state: got %0d want %0d", dut.r_state, S_IDLE); else n_pass++;
    tick(); tick();
    rst_n = 1'b1; flush = 1'b0; nv = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (valid) nv++; end
    n_total++; if (nv !== 0) $display("FAIL rmr_no_issue: got %0d valids want 0", nv); else n_pass++;
    n_total++; if (dut.r_state !== S_IDLE) $display("FAIL rmr_idle: got %0d want %0d", dut.r_state, S_IDLE); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_ii();
    test_stall();
    test_flush_mid_run();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
